// File: rtl/fp_mul_sequencer_pkg.sv
// Shared definitions for the sequential single-precision multiplier control path.
// Holds the default sizing constants, the exponent bias used by the datapath,
// the FSM state encoding, and the Moore strobe decode used by the sequencer.
package fp_mul_sequencer_pkg;

  localparam int unsigned MantWidth = 24;   // mantissa incl. hidden bit
  localparam int unsigned CntWidth  = 5;    // iteration counter width
  localparam int unsigned ExpBias   = 127;  // single-precision exponent bias

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StInit = 3'd2,
    StMul  = 3'd3,
    StPrep = 3'd4,
    StZero = 3'd5,
    StDone = 3'd6
  } state_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic ld_a;
    logic ld_b;
    logic init_p;
    logic ld_exp;
    logic sh_p;
    logic sel_zero;
    logic ld_res;
  } ctrl_t;

  // Moore strobes for a given state. addP is not here because it also
  // depends on the multiplier LSB.
  function automatic ctrl_t ctrl_decode(state_e st);
    ctrl_t c;
    c      = '0;
    c.busy = (st != StIdle);
    unique case (st)
      StLoad: begin
        c.ld_a = 1'b1;
        c.ld_b = 1'b1;
      end
      StInit: begin
        c.init_p = 1'b1;
        c.ld_exp = 1'b1;
      end
      StMul:  c.sh_p = 1'b1;
      StPrep: c.ld_res = 1'b1;
      StZero: begin
        c.ld_res   = 1'b1;
        c.sel_zero = 1'b1;
      end
      StDone: c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fp_mul_iter_counter.sv
// Loadable down-counter with zero flag for the shift-add multiply loop.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears count)
//   load      - load load_val (has priority over dec)
//   load_val  - value to load
//   dec       - decrement by one; saturates at zero
//   cnt       - current count
//   zero      - cnt == 0
module fp_mul_iter_counter
  import fp_mul_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = CntWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && !zero) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);
  assign cnt  = cnt_q;

endmodule

// File: rtl/fp_mul_sequencer.sv
// Control sequencer for the sequential single-precision multiplier.
// Per operation: operand load, exponent add + product clear, MANT_W shift-add
// iterations, then normalise/round/pack capture. A zero exponent on either
// operand skips the multiply loop and selects the signed-zero result.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - request an operation (sampled only in IDLE)
//   q0            - multiplier register LSB
//   zeroA, zeroB  - operand exponent field is zero
//   busy, done    - handshake status; done is a one-cycle result-valid pulse
//   ldA, ldB      - operand register loads
//   initP, ldExp  - product clear / multiplier load, exponent capture
//   addP, shP     - shift-add loop controls
//   selZero, ldRes- result mux select and result register load
//   cnt           - iteration index (debug)
module fp_mul_sequencer
  import fp_mul_sequencer_pkg::*;
#(
  parameter int unsigned MANT_W = MantWidth,
  parameter int unsigned CNT_W  = CntWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q0,
  input  logic             zeroA,
  input  logic             zeroB,
  output logic             busy,
  output logic             done,
  output logic             ldA,
  output logic             ldB,
  output logic             initP,
  output logic             ldExp,
  output logic             addP,
  output logic             shP,
  output logic             selZero,
  output logic             ldRes,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(MANT_W - 1);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   cnt_zero;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StInit;
      StInit:  state_d = (zeroA || zeroB) ? StZero : StMul;
      StMul:   if (cnt_zero) state_d = StPrep;
      StPrep:  state_d = StDone;
      StZero:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet still
  // line up cycle-for-cycle with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_decode(state_d);
    end
  end

  fp_mul_iter_counter #(
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == StInit),
    .load_val (CntInit),
    .dec      (state_q == StMul),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign busy    = ctrl_q.busy;
  assign done    = ctrl_q.done;
  assign ldA     = ctrl_q.ld_a;
  assign ldB     = ctrl_q.ld_b;
  assign initP   = ctrl_q.init_p;
  assign ldExp   = ctrl_q.ld_exp;
  assign shP     = ctrl_q.sh_p;
  assign selZero = ctrl_q.sel_zero;
  assign ldRes   = ctrl_q.ld_res;
  // shP is only ever high in MUL, so this gates addP to the multiply loop.
  assign addP    = ctrl_q.sh_p & q0;

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Bench for fp_mul_sequencer: a behavioural multiplier datapath driven by the
// sequencer strobes, per-cycle strobe/counter checks, and a result scoreboard.
module tb_fp_mul_sequencer;

  localparam int unsigned CNT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic q0, zeroA, zeroB;
  logic busy, done, ldA, ldB, initP, ldExp, addP, shP, selZero, ldRes;
  logic [CNT_W-1:0] cnt;

  always #5 clk = ~clk;

  fp_mul_sequencer #(
    .MANT_W (24),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .q0      (q0),
    .zeroA   (zeroA),
    .zeroB   (zeroB),
    .busy    (busy),
    .done    (done),
    .ldA     (ldA),
    .ldB     (ldB),
    .initP   (initP),
    .ldExp   (ldExp),
    .addP    (addP),
    .shP     (shP),
    .selZero (selZero),
    .ldRes   (ldRes),
    .cnt     (cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural datapath ----------------
  logic [31:0] op_a = '0, op_b = '0;
  logic [31:0] a_q = '0, b_q = '0, res_q = '0;
  logic [23:0] p_q = '0, m_q = '0;
  int          e_q = 0;

  assign q0    = m_q[0];
  assign zeroA = (a_q[30:23] == 8'd0);
  assign zeroB = (b_q[30:23] == 8'd0);

  function automatic logic [31:0] pack(input logic sign, input logic [47:0] prod, input int e);
    logic [23:0] mant;
    logic        g, s;
    int          ex;
    ex = e;
    if (prod[47]) begin
      mant = {1'b0, prod[46:24]};
      g    = prod[23];
      s    = |prod[22:0];
      ex   = ex + 1;
    end else begin
      mant = {1'b0, prod[45:23]};
      g    = prod[22];
      s    = |prod[21:0];
    end
    if (g && (s || mant[0])) mant = mant + 24'd1;
    if (mant[23]) begin
      mant = '0;
      ex   = ex + 1;
    end
    pack = {sign, ex[7:0], mant[22:0]};
  endfunction

  always @(posedge clk) begin : dp
    logic [24:0] sum;
    if (ldA) a_q <= op_a;
    if (ldB) b_q <= op_b;
    if (initP) begin
      p_q <= '0;
      m_q <= {1'b1, b_q[22:0]};
    end
    if (ldExp) e_q <= int'(a_q[30:23]) + int'(b_q[30:23]) - 127;
    if (shP) begin
      sum = {1'b0, p_q} + (addP ? {2'b01, a_q[22:0]} : 25'd0);
      p_q <= sum[24:1];
      m_q <= {sum[0], m_q[23:1]};
    end
    if (ldRes) res_q <= selZero ? {a_q[31] ^ b_q[31], 31'd0}
                                : pack(a_q[31] ^ b_q[31], {p_q, m_q}, e_q);
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [31:0] res;
    int          addp;
  } sb_t;

  sb_t sb_q[$];
  int  done_cycles[$];
  int  cycle = 0;
  int  addp_cnt = 0;

  always @(negedge clk) begin
    sb_t e;
    cycle++;
    if (!rst) begin
      check_val("addp_vs_q0", 64'(addP), 64'(shP & q0));
      if (ldA) addp_cnt = 0;
      else if (addP) addp_cnt++;
      if (done) begin
        done_cycles.push_back(cycle);
        if (sb_q.size() == 0) begin
          check_val("sb_pending", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          check_val("result", 64'(res_q), 64'(e.res));
          check_val("addp_count", 64'(addp_cnt), 64'(e.addp));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [8:0] obs_vec();
    return {busy, done, ldA, ldB, initP, ldExp, shP, selZero, ldRes};
  endfunction

  // Expected {busy,done,ldA,ldB,initP,ldExp,shP,selZero,ldRes} in cycle i after start.
  function automatic logic [8:0] exp_vec(input int i, input bit zero_path);
    if (i == 1) return 9'b1_0_11_00_0_0_0;
    if (i == 2) return 9'b1_0_00_11_0_0_0;
    if (zero_path) begin
      if (i == 3) return 9'b1_0_00_00_0_1_1;
      if (i == 4) return 9'b1_1_00_00_0_0_0;
      return 9'b0;
    end
    if (i <= 26) return 9'b1_0_00_00_1_0_0;
    if (i == 27) return 9'b1_0_00_00_0_0_1;
    if (i == 28) return 9'b1_1_00_00_0_0_0;
    return 9'b0;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                        input int addp, input bit zero_path);
    int n;
    sb_q.push_back('{res: res, addp: addp});
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = zero_path ? 5 : 29;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check_val($sformatf("strobes_c%0d", i), 64'(obs_vec()), 64'(exp_vec(i, zero_path)));
      if (!zero_path && i >= 3 && i <= 28)
        check_val($sformatf("cnt_c%0d", i), 64'(cnt), (i <= 26) ? 64'(26 - i) : 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    // Reset, then idle.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("reset_strobes", 64'(obs_vec()), 64'd0);
      check_val("reset_cnt", 64'(cnt), 64'd0);
    end

    // 1.5 * 2.0
    run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 1, 1'b0);
    // Zero shortcut
    run_op(32'h00000000, 32'h40490FDB, 32'h00000000, 0, 1'b1);
    // Sign / rounding case
    run_op(32'hBF800001, 32'h3F800001, 32'hBF800002, 2, 1'b0);

    // Reset during MUL iteration 10.
    sb_q.push_back('{res: 32'h40400000, addp: 1});
    op_a  = 32'h3FC00000;
    op_b  = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    check_val("mid_cnt", 64'(cnt), 64'd14);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_val("abort_strobes", 64'(obs_vec()), 64'd0);
    check_val("abort_cnt", 64'(cnt), 64'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_val("abort_quiet", 64'(ldRes | done | busy), 64'd0);
    end
    run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 1, 1'b0);

    // start held high: three operations, done pulses 29 cycles apart.
    done_cycles.delete();
    repeat (3) sb_q.push_back('{res: 32'h40400000, addp: 1});
    op_a  = 32'h3FC00000;
    op_b  = 32'h40000000;
    start = 1'b1;
    waited = 0;
    while (done_cycles.size() < 3 && waited < 150) begin
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    check_val("hold_done_count", 64'(done_cycles.size()), 64'd3);
    if (done_cycles.size() >= 3) begin
      check_val("hold_gap1", 64'(done_cycles[1] - done_cycles[0]), 64'd29);
      check_val("hold_gap2", 64'(done_cycles[2] - done_cycles[1]), 64'd29);
    end
    repeat (35) @(negedge clk);
    check_val("hold_idle_busy", 64'(busy), 64'd0);
    check_val("hold_sb_drained", 64'(sb_q.size()), 64'd0);
    check_val("hold_no_extra", 64'(done_cycles.size()), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
